// File: rtl/demux_8ch_scheduler.sv
// demux_8ch_scheduler
// Single-beat buffered 1-to-8 demultiplexer. Each accepted source beat is held
// in one output buffer and presented to exactly one channel, chosen either by
// a bursting round-robin pointer over the enabled channels (mode = 0) or by
// in_sel (mode = 1). Addressed beats aimed at a disabled channel are swallowed
// and counted as drops.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   mode                  0 = round-robin, 1 = addressed
//   in_sel                destination channel in addressed mode
//   in_valid/in_data      source beat
//   in_ready              combinational accept indication
//   chan_en               per-channel enable mask
//   out_valid             one-hot valid of the held beat (all zero when empty)
//   out_data              shared data bus (held beat)
//   out_ready             per-channel sink ready
//   cur_chan              channel of the held beat
//   drop_pulse            one-cycle flag following a dropped beat
//   drop_cnt              saturating dropped-beat count
module demux_8ch_scheduler #(
    parameter int unsigned DW    = 8,
    parameter int unsigned BURST = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic [2:0]    in_sel,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic [7:0]    chan_en,
    output logic [7:0]    out_valid,
    output logic [DW-1:0] out_data,
    input  logic [7:0]    out_ready,
    output logic [2:0]    cur_chan,
    output logic          drop_pulse,
    output logic [7:0]    drop_cnt
);

    localparam int unsigned CW  = 3;
    localparam int unsigned BCW = 5;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    logic [DW-1:0]   buf_data;
    logic [CW-1:0]   buf_chan;
    logic [CW-1:0]   ptr;
    logic [BCW-1:0]  beat_cnt;

    logic            drain;
    logic            accept;
    logic            drop;
    logic            load;
    logic            stay;
    logic            found;
    logic [CW-1:0]   rr_next;
    logic [CW-1:0]   rr_target;
    logic [CW-1:0]   load_chan;

    assign out_data = buf_data;
    assign cur_chan = buf_chan;

    // Handshake and target selection
    always_comb begin
        drain     = 1'b0;
        in_ready  = 1'b0;
        accept    = 1'b0;
        drop      = 1'b0;
        load      = 1'b0;
        stay      = 1'b0;
        found     = 1'b0;
        rr_next   = ptr;
        rr_target = ptr;
        load_chan = ptr;

        drain    = (state == FULL) && out_ready[buf_chan];
        in_ready = ((state == EMPTY) || drain) && (mode || (chan_en != 8'h00));
        accept   = in_valid && in_ready;

        // Keep bursting on ptr while it is enabled and the burst is not used up
        stay = chan_en[ptr] && (beat_cnt < BCW'(BURST));

        // First enabled channel after ptr; the eighth step wraps back to ptr itself
        for (int i = 1; i <= 8; i++) begin
            if (!found && chan_en[ptr + CW'(i)]) begin
                rr_next = ptr + CW'(i);
                found   = 1'b1;
            end
        end
        rr_target = stay ? ptr : rr_next;

        drop      = accept && mode && !chan_en[in_sel];
        load      = accept && !drop;
        load_chan = mode ? in_sel : rr_target;
    end

    // Buffer state, round-robin bookkeeping and drop accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            buf_data   <= '0;
            buf_chan   <= '0;
            out_valid  <= 8'h00;
            ptr        <= '0;
            beat_cnt   <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= 8'h00;
        end else begin
            drop_pulse <= drop;
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            if (load) begin
                state     <= FULL;
                buf_data  <= in_data;
                buf_chan  <= load_chan;
                out_valid <= 8'h01 << load_chan;
                if (!mode) begin
                    ptr      <= rr_target;
                    beat_cnt <= stay ? (beat_cnt + BCW'(1)) : BCW'(1);
                end
            end else if (drain) begin
                // Plain drain, or drain alongside a dropped beat
                state     <= EMPTY;
                out_valid <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_demux_8ch_scheduler.sv
// Testbench for demux_8ch_scheduler: directed scenarios plus random traffic.
// Accepted beats are predicted by a reference model and queued; a monitor
// compares them whenever the DUT presents a beat.
module tb_demux_8ch_scheduler;

    localparam int unsigned DW    = 8;
    localparam int unsigned BURST = 2;

    logic          clk;
    logic          rst;
    logic          mode;
    logic [2:0]    in_sel;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [7:0]    chan_en;
    logic [7:0]    out_valid;
    logic [DW-1:0] out_data;
    logic [7:0]    out_ready;
    logic [2:0]    cur_chan;
    logic          drop_pulse;
    logic [7:0]    drop_cnt;

    demux_8ch_scheduler #(
        .DW    (DW),
        .BURST (BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .chan_en    (chan_en),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .cur_chan   (cur_chan),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    chan;
        logic [DW-1:0] data;
    } beat_t;

    beat_t sbq[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: held beat plus round-robin position
    bit m_full;
    int m_chan;
    int m_ptr;
    int m_cnt;
    int m_drop_cnt;
    bit m_drop_pulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full       = 1'b0;
        m_chan       = 0;
        m_ptr        = 0;
        m_cnt        = 0;
        m_drop_cnt   = 0;
        m_drop_pulse = 1'b0;
        sbq.delete();
    endtask

    // Predict what the coming clock edge does with the inputs now applied
    task automatic model_step();
        bit drain;
        bit rdy;
        bit acc;
        int t;
        drain = m_full && out_ready[m_chan];
        rdy   = (!m_full || drain) && (mode || (chan_en != 8'h00));
        chk("in_ready", 32'(in_ready), 32'(rdy));
        acc = in_valid && rdy;
        m_drop_pulse = 1'b0;
        if (acc && mode && !chan_en[in_sel]) begin
            m_drop_pulse = 1'b1;
            if (m_drop_cnt < 255) m_drop_cnt++;
            if (drain) m_full = 1'b0;
        end else if (acc) begin
            if (mode) begin
                t = int'(in_sel);
            end else begin
                if (chan_en[m_ptr] && (m_cnt < int'(BURST))) begin
                    t = m_ptr;
                    m_cnt++;
                end else begin
                    t = -1;
                    for (int k = 1; k <= 8; k++) begin
                        if (t < 0 && chan_en[(m_ptr + k) % 8]) t = (m_ptr + k) % 8;
                    end
                    m_cnt = 1;
                end
                m_ptr = t;
            end
            m_full = 1'b1;
            m_chan = t;
            sbq.push_back('{chan: 3'(t), data: in_data});
        end else if (drain) begin
            m_full = 1'b0;
        end
    endtask

    // One clock: check registered outputs after the edge, then apply new inputs
    task automatic cycle(input logic m, input logic [2:0] sel, input logic v,
                         input logic [DW-1:0] d, input logic [7:0] en, input logic [7:0] ordy);
        @(posedge clk);
        #1;
        chk("out_valid_state", 32'(out_valid), m_full ? (32'(1) << m_chan) : 32'(0));
        chk("drop_pulse", 32'(drop_pulse), 32'(m_drop_pulse));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop_cnt));
        if (m_full) chk("cur_chan", 32'(cur_chan), 32'(m_chan));
        mode      = m;
        in_sel    = sel;
        in_valid  = v;
        in_data   = d;
        chan_en   = en;
        out_ready = ordy;
        #1;
        model_step();
    endtask

    // Assert reset between edges and check its asynchronous effect
    task automatic do_reset();
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_cur_chan", 32'(cur_chan), 32'(0));
        chk("rst_drop_pulse", 32'(drop_pulse), 32'(0));
        chk("rst_drop_cnt", 32'(drop_cnt), 32'(0));
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: compare the presented beat, pop on handshake
    always @(negedge clk) begin
        if (!rst && (out_valid != 8'h00)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_beat", 32'(out_valid), 32'(0));
            end else begin
                chk("sb_chan", 32'(out_valid), 32'(1) << sbq[0].chan);
                chk("sb_data", 32'(out_data), 32'(sbq[0].data));
                if ((out_ready & out_valid) != 8'h00) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rmode;
        logic [7:0]  ren;
        logic [7:0]  rrdy;

        rst       = 1'b1;
        mode      = 1'b0;
        in_sel    = 3'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        chan_en   = 8'h00;
        out_ready = 8'h00;
        model_reset();
        #1;
        chk("init_out_valid", 32'(out_valid), 32'(0));
        chk("init_drop_cnt", 32'(drop_cnt), 32'(0));
        chk("init_in_ready", 32'(in_ready), 32'(0));
        #11;
        rst = 1'b0;

        // Back-to-back round-robin over all channels
        for (int i = 0; i < 9; i++) cycle(1'b0, 3'd0, 1'b1, DW'(8'h10 + i), 8'hFF, 8'hFF);
        cycle(1'b0, 3'd0, 1'b0, '0, 8'hFF, 8'hFF);

        // Sparse mask, then an empty mask
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1'b0, 3'd0, 1'b1, DW'(8'h20 + i), 8'hA4, 8'hFF);
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 1'b1, DW'(8'h30 + i), 8'h00, 8'hFF);

        // Bursting over two channels
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, 1'b1, DW'(8'h40 + i), 8'h03, 8'hFF);
        cycle(1'b0, 3'd0, 1'b0, '0, 8'h03, 8'hFF);

        // Backpressure on channel 0, then drain and reload together
        do_reset();
        cycle(1'b0, 3'd0, 1'b1, 8'hA5, 8'h01, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 1'b1, 8'h3C, 8'h01, 8'h00);
        cycle(1'b0, 3'd0, 1'b1, 8'h3C, 8'h01, 8'h01);
        cycle(1'b0, 3'd0, 1'b0, '0, 8'h01, 8'h01);
        cycle(1'b0, 3'd0, 1'b0, '0, 8'h01, 8'h01);

        // Addressed drops to a disabled channel, up to saturation
        do_reset();
        cycle(1'b1, 3'd3, 1'b1, 8'h55, 8'hF7, 8'hFF);
        cycle(1'b1, 3'd3, 1'b0, 8'h00, 8'hF7, 8'hFF);
        cycle(1'b1, 3'd3, 1'b0, 8'h00, 8'hF7, 8'hFF);
        for (int i = 0; i < 300; i++) cycle(1'b1, 3'd3, 1'b1, DW'(i), 8'hF7, 8'hFF);
        cycle(1'b1, 3'd6, 1'b1, 8'h66, 8'hF7, 8'hFF);
        cycle(1'b1, 3'd3, 1'b1, 8'h67, 8'hF7, 8'hFF);
        cycle(1'b1, 3'd0, 1'b0, 8'h00, 8'hF7, 8'hFF);

        // Reset while a beat is held on channel 2
        do_reset();
        cycle(1'b0, 3'd0, 1'b1, 8'h77, 8'h04, 8'h00);
        cycle(1'b0, 3'd0, 1'b0, 8'h00, 8'h04, 8'h00);
        do_reset();
        cycle(1'b0, 3'd0, 1'b1, 8'h11, 8'hFF, 8'hFF);
        cycle(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 8'hFF);

        // Random traffic with mode and mask changes under backpressure
        rmode = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) rmode = ~rmode;
            case ($urandom_range(0, 7))
                0:       ren = 8'h00;
                1:       ren = 8'hFF;
                default: ren = 8'($urandom);
            endcase
            rrdy = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            cycle(rmode, 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
                  DW'($urandom), ren, rrdy);
        end

        // Flush whatever is still held
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 1'b0, '0, 8'hFF, 8'hFF);
        chk("sb_empty", 32'(sbq.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
